breath_pwm: RTL and testbench

PWM modulator that consumes the brightness sequence of the breathing-LED counter and drives the LED pin.
- Accepts a duty level through a valid/ready handshake and holds it in a shadow register.
- Commits the level to the active duty register only at a period boundary, so the waveform never glitches.
- Emits a period-end strobe that the producer uses as its step/clock enable.

---
 rtl/breath_pkg.sv | 17 +
 rtl/tick_divider.sv | 36 +++
 rtl/breath_pwm.sv | 116 +++++++++++
 tb/tb_breath_pwm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED slice: full-on pattern macro and gamma rounding constant.
// Guarded so the breathing-LED files can pull it in alongside breath_pwm.
`ifndef BREATH_PKG_SV
`define BREATH_PKG_SV

`define BREATH_FULL_ON(W) {(W){1'b1}}

package breath_pkg;

    // Half of one output LSB after the >>bits rescale, so the squared level rounds to nearest.
    function automatic int unsigned gamma_round(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

endpackage

`endif

// File: rtl/tick_divider.sv
// Prescaler producing a one-clock tick every PRESCALE clocks; PRESCALE=1 ticks every clock.
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero on the tick clock.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/breath_pwm.sv
// Glitch-free PWM modulator: shadowed duty level committed only at period end.
// Optional gamma correction at accept time under macro BREATH_PWM_GAMMA_EN.
module breath_pwm
    import breath_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [BITS-1:0] level,
    input  logic            level_valid,
    output logic            level_ready,
    output logic            pwm,
    output logic            period_end
);

    localparam logic [BITS-1:0] FULL = `BREATH_FULL_ON(BITS);

    logic            tick_s;
    logic            last_s;
    logic            accept_s;
    logic [BITS-1:0] level_conv_s;

    logic [BITS-1:0] phase_q, phase_d;
    logic [BITS-1:0] duty_q, duty_d;
    logic [BITS-1:0] pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic            pwm_q, pwm_d;
    logic            period_end_q, period_end_d;

    tick_divider #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick_o (tick_s)
    );

`ifdef BREATH_PWM_GAMMA_EN
    logic [2*BITS-1:0] sq_s;

    // Rounded square of the level; all-ones is forced so full brightness stays reachable.
    always_comb begin
        sq_s = ({{BITS{1'b0}}, level} * {{BITS{1'b0}}, level}) + (2*BITS)'(gamma_round(BITS));
        if (level == FULL) begin
            level_conv_s = FULL;
        end else begin
            level_conv_s = BITS'(sq_s >> BITS);
        end
    end
`else
    // Level passes through untouched.
    always_comb begin
        level_conv_s = level;
    end
`endif

    assign last_s   = tick_s && (phase_q == FULL);
    assign accept_s = level_valid && !pend_full_q;

    // Next state: phase advance, shadow capture, and commit at the period boundary.
    always_comb begin
        phase_d      = phase_q;
        duty_d       = duty_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        if (tick_s) begin
            phase_d = phase_q + BITS'(1);
        end else begin
            phase_d = phase_q;
        end
        if (last_s) begin
            if (pend_full_q) begin
                duty_d      = pend_q;
                pend_full_d = 1'b0;
            end else if (accept_s) begin
                // Empty shadow on the boundary clock: skip it and commit directly.
                duty_d = level_conv_s;
            end else begin
                duty_d = duty_q;
            end
        end else if (accept_s) begin
            pend_d      = level_conv_s;
            pend_full_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        pwm_d        = (phase_q < duty_q) || (duty_q == FULL);
        period_end_d = last_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q      <= {BITS{1'b0}};
            duty_q       <= {BITS{1'b0}};
            pend_q       <= {BITS{1'b0}};
            pend_full_q  <= 1'b0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign level_ready = !pend_full_q;
    assign pwm         = pwm_q;
    assign period_end  = period_end_q;

endmodule

// File: tb/tb_breath_pwm.sv
// Self-checking bench for breath_pwm: directed test-plan scenarios plus random traffic against a cycle-count model.
module tb_breath_pwm;

    localparam int BITS = 4;
    localparam int PS   = 1;
    localparam int N    = 1 << BITS;
    localparam int P    = PS * N;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [BITS-1:0] level = '0;
    logic            level_valid = 1'b0;
    logic            level_ready;
    logic            pwm;
    logic            period_end;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: clocks since reset, active duty, shadow queue (depth 1).
    int k = 0;
    int m_duty = 0;
    int m_pend[$];
    int e_pwm = 0;
    int e_pe = 0;
    int e_rdy = 1;
    bit m_acc = 1'b0;
    int hi_cnt = 0;
    int pe_cnt = 0;

    breath_pwm #(
        .BITS    (BITS),
        .PRESCALE(PS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .level      (level),
        .level_valid(level_valid),
        .level_ready(level_ready),
        .pwm        (pwm),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gam(input int l);
`ifdef BREATH_PWM_GAMMA_EN
        if (l == N - 1) return N - 1;
        return (l * l + N / 2) / N;
`else
        return l;
`endif
    endfunction

    // One clock: drive on the falling edge, advance the model, compare 1 time unit after the rising edge.
    task automatic step(input bit rn, input bit v, input int lv);
        int ph;
        bit last;
        @(negedge clk);
        reset_n     = rn;
        level_valid = v;
        level       = lv[BITS-1:0];
        @(posedge clk);
        #1;
        if (!rn) begin
            k      = 0;
            m_duty = 0;
            m_pend.delete();
            e_pwm  = 0;
            e_pe   = 0;
            m_acc  = 1'b0;
        end else begin
            ph    = (k / PS) % N;
            last  = ((k % P) == P - 1);
            e_pwm = ((ph < m_duty) || (m_duty == N - 1)) ? 1 : 0;
            e_pe  = last ? 1 : 0;
            m_acc = v && (m_pend.size() == 0);
            if (last) begin
                if (m_pend.size() != 0) m_duty = m_pend.pop_front();
                else if (m_acc) m_duty = gam(lv);
            end else if (m_acc) begin
                m_pend.push_back(gam(lv));
            end
            k++;
        end
        e_rdy = (m_pend.size() == 0) ? 1 : 0;
        chk_eq("pwm", int'(pwm), e_pwm);
        chk_eq("period_end", int'(period_end), e_pe);
        chk_eq("level_ready", int'(level_ready), e_rdy);
        hi_cnt += int'(pwm);
        pe_cnt += int'(period_end);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    task automatic align_to(input int r);
        for (int i = 0; i < P && (k % P) != r; i++) step(1'b1, 1'b0, 0);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 0);

        hi_cnt = 0; pe_cnt = 0;
        idle(32);
        chk_eq("idle_period_end_pulses", pe_cnt, 2);
        chk_eq("idle_pwm_high", hi_cnt, 0);

        idle(5);
        step(1'b1, 1'b1, 4);
        idle(40);
        align_to(0);
        hi_cnt = 0; idle(P);
        chk_eq("duty4_high_per_period", hi_cnt, gam(4));

        step(1'b1, 1'b1, 15);
        idle(40);
        hi_cnt = 0; idle(2 * P);
        chk_eq("duty15_high_two_periods", hi_cnt, 2 * P);

        step(1'b1, 1'b1, 0);
        idle(40);
        hi_cnt = 0; idle(P);
        chk_eq("duty0_high_per_period", hi_cnt, 0);

        // Back-to-back offers: the second must wait for the next commit.
        align_to(3);
        step(1'b1, 1'b1, 6);
        for (int i = 0; i < 2 * P; i++) begin
            step(1'b1, 1'b1, 9);
            if (m_acc) break;
        end
        align_to(0);
        hi_cnt = 0; idle(P);
        chk_eq("stalled9_high_per_period", hi_cnt, gam(9));

        // Offer exactly on the boundary clock with an empty shadow.
        align_to(P - 1);
        step(1'b1, 1'b1, 3);
        hi_cnt = 0; idle(P);
        chk_eq("bypass3_high_per_period", hi_cnt, gam(3));

        // Mid-period reset with both active and shadow levels loaded.
        step(1'b1, 1'b1, 10);
        idle(P + 2);
        step(1'b1, 1'b1, 5);
        idle(2);
        step(1'b0, 1'b0, 0);
        hi_cnt = 0; idle(3 * P);
        chk_eq("after_reset_high", hi_cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, N - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
